// File: rtl/package_settings.sv
// ============================================================================
// Module      : package_settings
// Description : Shared widths, sequencer defaults and the sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package package_settings;

  localparam int DEFAULT_SIZE_FILTER_DATA = 16;
  localparam int DEFAULT_SIZE_DELAY       = 8;
  localparam int SIZE_SEQ_STEPS           = 4;
  localparam int DEFAULT_SETTLE_CYCLES    = 16;
  localparam int DEFAULT_DWELL_CYCLES     = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    REPORT  = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/peak_tracker.sv
// ============================================================================
// Module      : peak_tracker
// Description : Window peak/first-position tracker with optional window sum
//               (sum enabled by macro FILTER_SEQ_AVG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peak_tracker #(
  parameter int DATA_W       = 16,
  parameter int DWELL_CYCLES = 64
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          clear,
  input  logic                                          enable,
  input  logic signed [DATA_W-1:0]                      data,
  output logic signed [DATA_W-1:0]                      peak,
  output logic        [$clog2(DWELL_CYCLES)-1:0]        pos,
  output logic signed [DATA_W+$clog2(DWELL_CYCLES)-1:0] sum,
  output logic                                          last
);

  localparam int                POS_W    = $clog2(DWELL_CYCLES);
  localparam int                SUM_W    = DATA_W + POS_W;
  localparam logic [POS_W-1:0]  LAST_IDX = POS_W'(DWELL_CYCLES - 1);

  logic signed [DATA_W-1:0] best;
  logic        [POS_W-1:0]  best_pos;
  logic        [POS_W-1:0]  idx;
  logic                     higher;

  // Strict compare keeps the earliest position on ties
  assign higher = enable && (data > best);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best     <= '0;
      best_pos <= '0;
      idx      <= '0;
    end else if (clear) begin
      best     <= {1'b1, {(DATA_W-1){1'b0}}};
      best_pos <= '0;
      idx      <= '0;
    end else if (enable) begin
      if (higher) begin
        best     <= data;
        best_pos <= idx;
      end
      idx <= idx + POS_W'(1);
    end
  end

  // Outputs include the sample being taken this cycle so the final sample
  // lands in the result loaded on the same edge.
  assign peak = higher ? data : best;
  assign pos  = higher ? idx  : best_pos;
  assign last = enable && (idx == LAST_IDX);

`ifdef FILTER_SEQ_AVG_EN
  logic signed [SUM_W-1:0] acc;
  logic signed [SUM_W-1:0] data_ext;

  assign data_ext = {{POS_W{data[DATA_W-1]}}, data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + data_ext;
    end
  end

  assign sum = enable ? (acc + data_ext) : acc;
`else
  assign sum = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/filter_test_sequencer.sv
// ============================================================================
// Module      : filter_test_sequencer
// Description : Delay-sweep controller: programs the generator, waits for the
//               filter to settle, reports the windowed peak of filter_data.
//               Window sum reported only when FILTER_SEQ_AVG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_test_sequencer
  import package_settings::*;
#(
  parameter int SIZE_FILTER_DATA = DEFAULT_SIZE_FILTER_DATA,
  parameter int SIZE_DELAY       = DEFAULT_SIZE_DELAY,
  parameter int SETTLE_CYCLES    = DEFAULT_SETTLE_CYCLES,
  parameter int DWELL_CYCLES     = DEFAULT_DWELL_CYCLES,
  parameter int DELAY_START      = 0,
  parameter int DELAY_STEP       = 4
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    start,
  input  logic                                                    abort,
  input  logic        [SIZE_SEQ_STEPS-1:0]                        cfg_steps,
  input  logic                                                    cfg_overlay,
  input  logic                                                    cfg_rate,
  input  logic signed [SIZE_FILTER_DATA-1:0]                      filter_data,
  input  logic                                                    result_ready,
  output logic                                                    test_overlay,
  output logic                                                    test_rate,
  output logic        [SIZE_DELAY-1:0]                            test_delay,
  output logic                                                    busy,
  output logic                                                    result_valid,
  output logic        [SIZE_SEQ_STEPS-1:0]                        result_step,
  output logic signed [SIZE_FILTER_DATA-1:0]                      result_peak,
  output logic        [$clog2(DWELL_CYCLES)-1:0]                  result_pos,
  output logic signed [SIZE_FILTER_DATA+$clog2(DWELL_CYCLES)-1:0] result_sum,
  output logic                                                    done
);

  localparam int                      POS_W       = $clog2(DWELL_CYCLES);
  localparam int                      SUM_W       = SIZE_FILTER_DATA + POS_W;
  localparam int                      SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0]     SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SIZE_DELAY-1:0]   DELAY_MAX   = '1;

  seq_state_t                   state;
  logic [SETTLE_W-1:0]          settle_cnt;
  logic [SIZE_SEQ_STEPS-1:0]    step;
  logic [SIZE_SEQ_STEPS-1:0]    last_step;
  logic [31:0]                  delay_sum;
  logic [SIZE_DELAY-1:0]        delay_next;
  logic                         trk_clear;
  logic                         trk_enable;
  logic                         trk_last;
  logic signed [SIZE_FILTER_DATA-1:0] trk_peak;
  logic        [POS_W-1:0]            trk_pos;
  logic signed [SUM_W-1:0]            trk_sum;

  // Next sweep delay saturates at the top of the delay range
  assign delay_sum  = 32'(test_delay) + 32'(DELAY_STEP);
  assign delay_next = (delay_sum > 32'(DELAY_MAX)) ? DELAY_MAX : delay_sum[SIZE_DELAY-1:0];

  assign trk_clear  = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
  assign trk_enable = (state == MEASURE);

  peak_tracker #(
    .DATA_W       (SIZE_FILTER_DATA),
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_peak_tracker (
    .clk    (clk),
    .reset  (reset),
    .clear  (trk_clear),
    .enable (trk_enable),
    .data   (filter_data),
    .peak   (trk_peak),
    .pos    (trk_pos),
    .sum    (trk_sum),
    .last   (trk_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      step         <= '0;
      last_step    <= '0;
      test_overlay <= 1'b0;
      test_rate    <= 1'b0;
      test_delay   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result_step  <= '0;
      result_peak  <= '0;
      result_pos   <= '0;
      result_sum   <= '0;
    end else if (abort && (state != IDLE)) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= SETTLE;
            busy         <= 1'b1;
            settle_cnt   <= '0;
            step         <= '0;
            last_step    <= (cfg_steps == '0) ? '0 : cfg_steps - 1'b1;
            test_overlay <= cfg_overlay;
            test_rate    <= cfg_rate;
            test_delay   <= SIZE_DELAY'(DELAY_START);
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= MEASURE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (trk_last) begin
            state        <= REPORT;
            result_valid <= 1'b1;
            result_step  <= step;
            result_peak  <= trk_peak;
            result_pos   <= trk_pos;
            result_sum   <= trk_sum;
          end
        end
        REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (step == last_step) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= SETTLE;
              step       <= step + 1'b1;
              settle_cnt <= '0;
              test_delay <= delay_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_filter_test_sequencer.sv
// ============================================================================
// Module      : tb_filter_test_sequencer
// Description : Self-checking bench for filter_test_sequencer; window sum
//               expectations follow macro FILTER_SEQ_AVG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_test_sequencer;

  localparam int SETTLE = 16;
  localparam int DWELL  = 64;
  localparam int DW     = 16;
  localparam int SD     = 8;
  localparam int SD2    = 4;
  localparam int HIST   = 8192;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [3:0] cfg_steps = '0;
  logic cfg_overlay = 1'b0;
  logic cfg_rate = 1'b0;
  logic signed [DW-1:0] filter_data = '0;
  logic result_ready = 1'b0;

  logic test_overlay, test_rate, busy, result_valid, done;
  logic [SD-1:0] test_delay;
  logic [3:0] result_step;
  logic signed [DW-1:0] result_peak;
  logic [5:0] result_pos;
  logic signed [DW+5:0] result_sum;

  logic test_overlay2, test_rate2, busy2, result_valid2, done2;
  logic [SD2-1:0] test_delay2;
  logic [3:0] result_step2;
  logic signed [DW-1:0] result_peak2;
  logic [5:0] result_pos2;
  logic signed [DW+5:0] result_sum2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mode = 0;
  int ramp_base = 0;
  logic signed [DW-1:0] const_val = '0;
  logic signed [DW-1:0] hist [HIST];

  filter_test_sequencer #(
    .SIZE_FILTER_DATA(DW), .SIZE_DELAY(SD), .SETTLE_CYCLES(SETTLE),
    .DWELL_CYCLES(DWELL), .DELAY_START(0), .DELAY_STEP(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_steps(cfg_steps), .cfg_overlay(cfg_overlay), .cfg_rate(cfg_rate),
    .filter_data(filter_data), .result_ready(result_ready),
    .test_overlay(test_overlay), .test_rate(test_rate), .test_delay(test_delay),
    .busy(busy), .result_valid(result_valid), .result_step(result_step),
    .result_peak(result_peak), .result_pos(result_pos), .result_sum(result_sum),
    .done(done)
  );

  // Narrow delay range starting near the top to exercise saturation
  filter_test_sequencer #(
    .SIZE_FILTER_DATA(DW), .SIZE_DELAY(SD2), .SETTLE_CYCLES(SETTLE),
    .DWELL_CYCLES(DWELL), .DELAY_START(12), .DELAY_STEP(4)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_steps(cfg_steps), .cfg_overlay(cfg_overlay), .cfg_rate(cfg_rate),
    .filter_data(filter_data), .result_ready(result_ready),
    .test_overlay(test_overlay2), .test_rate(test_rate2), .test_delay(test_delay2),
    .busy(busy2), .result_valid(result_valid2), .result_step(result_step2),
    .result_peak(result_peak2), .result_pos(result_pos2), .result_sum(result_sum2),
    .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hist[cyc % HIST] = filter_data;
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    case (mode)
      0:       filter_data = DW'($urandom);
      1:       filter_data = DW'(cyc - ramp_base);
      2:       filter_data = const_val;
      default: filter_data = DW'($urandom_range(0, 6)) - 16'd3;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] fsum(input longint v);
`ifdef FILTER_SEQ_AVG_EN
    return v;
`else
    return 64'(v - v);
`endif
  endfunction

  // Window begins SETTLE+1 edges after the edge that started the step
  task automatic model(input int p, output logic signed [DW-1:0] pk, output int ps, output longint sm);
    logic signed [DW-1:0] v;
    pk = hist[(p + SETTLE + 1) % HIST];
    ps = 0;
    sm = 0;
    for (int k = 0; k < DWELL; k++) begin
      v = hist[(p + SETTLE + 1 + k) % HIST];
      sm += longint'(v);
      if (v > pk) begin
        pk = v;
        ps = k;
      end
    end
  endtask

  task automatic run_sweep(input int steps, input int m, input int bp, input bit hold,
                           input logic ovl, input logic rt, input bit fixed,
                           input int fpk, input int fps, input longint fsm);
    int n, p, waited, e1, e2, ps;
    logic signed [DW-1:0] pk;
    longint sm;
    n = (steps == 0) ? 1 : steps;
    @(negedge clk);
    cfg_steps = 4'(steps);
    cfg_overlay = ovl;
    cfg_rate = rt;
    mode = m;
    start = 1'b1;
    p = cyc;
    ramp_base = p + SETTLE + 1;
    result_ready = hold;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("overlay", test_overlay, ovl);
    chk("rate", test_rate, rt);
    for (int s = 0; s < n; s++) begin
      waited = 0;
      while (!result_valid && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      e1 = (4 * s > 255) ? 255 : 4 * s;
      e2 = (12 + 4 * s > 15) ? 15 : 12 + 4 * s;
      model(p, pk, ps, sm);
      chk("latency", cyc - p, 1 + SETTLE + DWELL);
      chk("valid", result_valid, 1);
      chk("step", result_step, s);
      chk("peak", result_peak, pk);
      chk("pos", result_pos, ps);
      chk("sum", result_sum, fsum(sm));
      chk("delay", test_delay, e1);
      chk("delay_sat", test_delay2, e2);
      chk("peak_sat_dut", result_peak2, pk);
      chk("busy_in_report", busy, 1);
      chk("done_in_report", done, 0);
      if (fixed) begin
        chk("peak_fixed", result_peak, fpk);
        chk("pos_fixed", result_pos, fps);
        chk("sum_fixed", result_sum, fsum(fsm));
      end
      if (bp > 0) begin
        repeat (bp) @(negedge clk);
        chk("bp_valid", result_valid, 1);
        chk("bp_peak", result_peak, pk);
        chk("bp_pos", result_pos, ps);
        chk("bp_step", result_step, s);
        chk("bp_delay", test_delay, e1);
      end
      result_ready = 1'b1;
      p = cyc;
      @(negedge clk);
      if (!hold) result_ready = 1'b0;
      chk("valid_drop", result_valid, 0);
      chk("busy_after_hs", busy, 1);
      chk("done_after_hs", done, (s == n - 1) ? 1 : 0);
    end
    result_ready = 1'b0;
    @(negedge clk);
    chk("done_cleared", done, 0);
    chk("busy_cleared", busy, 0);
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_delay", test_delay, 0);
    chk("rst_delay_sat", test_delay2, 0);
    chk("rst_peak", result_peak, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep(1, 1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 63, 63, 2016);
    run_sweep(3, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    const_val = -16'sd5;
    run_sweep(2, 2, 10, 1'b0, 1'b1, 1'b1, 1'b1, -5, 0, -320);
    run_sweep(3, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    run_sweep(5, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);

    // Abort in the middle of the measurement window
    @(negedge clk);
    cfg_steps = 4'd2;
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE + 10) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_done", done, 0);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (result_valid || done || busy) cnt++;
    end
    chk("abort_quiet", cnt, 0);

    // Asynchronous reset during SETTLE
    @(negedge clk);
    cfg_steps = 4'd1;
    cfg_overlay = 1'b1;
    cfg_rate = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_overlay", test_overlay, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overlay", test_overlay, 0);
    chk("mid_rst_rate", test_rate, 0);
    chk("mid_rst_delay_sat", test_delay2, 0);
    chk("mid_rst_peak", result_peak, 0);
    chk("mid_rst_pos", result_pos, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_sweep(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    const_val = -16'sd2;
    run_sweep(1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1, -2, 0, -128);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/filter_test_sequencer.md
Name: filter_test_sequencer

Overview:
- Controller that sequences the filter test bench: programs the signal generator's overlay/rate/delay for each step of a delay sweep, waits for the filter pipeline to settle, then measures the peak of one filter output over a fixed window.
- Reports one result per step over a valid/ready handshake.
- Sits beside exp_sig_gen and v1_filter in the filter top level; drives test_overlay/test_rate/test_delay and observes output_data_v1.

Parameters:
- SETTLE_CYCLES, 16, cycles waited after a setting change before measuring (at least the filter latency).
- DWELL_CYCLES, 64, measurement window length in cycles (at least 2).
- DELAY_START, 0, test_delay value for step 0.
- DELAY_STEP, 4, increment of test_delay per step.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a sweep; ignored unless IDLE
- abort  in  1  terminate the sweep; highest priority
- cfg_steps  in  4  number of steps; 0 is treated as 1
- cfg_overlay  in  1  overlay setting applied for the whole sweep
- cfg_rate  in  1  rate setting applied for the whole sweep
- filter_data  in  SIZE_FILTER_DATA  signed filter output under test
- result_ready  in  1  consumer accepts the result
- test_overlay  out  1  to the generator
- test_rate  out  1  to the generator
- test_delay  out  SIZE_DELAY  to the generator
- busy  out  1  high in any state other than IDLE
- result_valid  out  1  result available
- result_step  out  4  step index of the result
- result_peak  out  SIZE_FILTER_DATA  signed maximum over the window
- result_pos  out  $clog2(DWELL_CYCLES)  window offset of the first maximum
- result_sum  out  SIZE_FILTER_DATA+$clog2(DWELL_CYCLES)  window sum (optional feature)
- done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (asynchronous assert on reset=0): state IDLE, all outputs 0, test_delay=0, step=0.
- The state machine is registered; all outputs are registered.
- IDLE:
  - test_* outputs hold their last values.
  - On start=1 -> SETTLE: latch cfg_*, step=0, test_delay=DELAY_START, test_overlay=cfg_overlay, test_rate=cfg_rate.
- SETTLE:
  - Counter runs 0..SETTLE_CYCLES-1, then -> MEASURE.
  - On entry to MEASURE: peak=most-negative value, pos=0, window counter=0.
- MEASURE:
  - Runs exactly DWELL_CYCLES cycles.
  - Each cycle: if filter_data > peak (signed, strict), peak=filter_data and pos=window counter. Ties keep the earliest position.
  - After the last sample -> REPORT; result_* are loaded in the same edge.
- REPORT:
  - result_valid=1; result_* are stable until the handshake.
  - Handshake occurs on an edge where result_valid && result_ready; result_valid drops the next cycle.
  - If step == eff_steps-1 -> DONE.
  - Otherwise step+1 -> SETTLE, with test_delay = test_delay + DELAY_STEP, saturating at 2**SIZE_DELAY-1 (never wraps).
- DONE: done=1 for one cycle -> IDLE. busy falls in the same cycle as the transition.
- abort=1 in any non-IDLE state -> IDLE on the next edge. result_valid=0 and done is not pulsed. Abort wins over a simultaneous handshake or start.
- start while busy: ignored, with no queuing.
- Reset mid-sweep: immediate return to reset values.
- Latency from start to the first result_valid: 1 + SETTLE_CYCLES + DWELL_CYCLES cycles.

Optional Feature:
- Macro FILTER_SEQ_AVG_EN.
- When defined: a signed accumulator is cleared on MEASURE entry and adds sign-extended filter_data every window cycle; result_sum is loaded with the total in REPORT.
- When undefined: no accumulator; result_sum is tied to 0.

Decomposition:
- package_settings adds:
  - typedef enum logic [2:0] seq_state_t {IDLE, SETTLE, MEASURE, REPORT, DONE}.
  - SIZE_SEQ_STEPS = 4.
  - Default localparams for SETTLE_CYCLES and DWELL_CYCLES.
- Sub-module: peak_tracker, with inputs clear, enable, data and outputs peak, pos, plus the optional sum. It holds the compare/accumulate datapath; the FSM stays in filter_test_sequencer.

Test Plan:
- Single step: cfg_steps=1; filter_data ramps 0..63 during MEASURE -> result_valid at cycle 81 after start; peak=63, pos=63, step=0; done pulse after the handshake.
- Sweep: cfg_steps=3, result_ready=1 -> test_delay takes values 0, 4, 8; three results with step 0, 1, 2; busy stays high throughout; one done pulse.
- Backpressure and ties: result_ready=0 for 10 cycles -> result_valid held and result_* stable; data constant −5 -> peak=−5, pos=0. The next step begins only after ready.
- Saturation: SIZE_DELAY=4, DELAY_START=12, cfg_steps=3 -> test_delay takes values 12, 15, 15.
- Abort and reset: abort asserted mid-MEASURE -> IDLE next cycle, no result, no done. reset=0 mid-SETTLE -> all outputs 0 immediately. cfg_steps=0 -> exactly one result.
- FILTER_SEQ_AVG_EN: constant −2 for 64 samples -> result_sum=−128. With the macro undefined, result_sum=0.
